bcd_to_bin_seq: RTL

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/sub3.sv | 9 +
 rtl/bcd_to_bin_seq.sv | 98 +++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared widths, state encoding and input-validity helper for the sequential BCD-to-binary converter.
package bcd_pkg;

  localparam int unsigned BCD_W = 16;
  localparam int unsigned BIN_W = 14;
  localparam int unsigned NDIG  = 4;
  localparam int unsigned ITERS = 14;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when any packed digit lies outside 0..9.
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/sub3.sv
// Combinational digit correction for reverse double-dabble: subtract 3 from a digit >= 8.
module sub3 (
  input  logic [3:0] din,
  output logic [3:0] dout_c
);

  assign dout_c = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential 4-digit BCD to 14-bit binary converter, one reverse double-dabble step per cycle.
// Optional macro BCD_CHECK_EN flags inputs with digits above 9 (err=1, result=0).
module bcd_to_bin_seq
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BCD_W-1:0] bcd_in,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] result,
  output logic             err
);

  state_t                       state_q, state_d;
  logic [BCD_W-1:0]             s_q;
  logic [BIN_W-1:0]             b_q;
  logic [CNT_W-1:0]             count_q;
  logic [BCD_W+BIN_W-1:0]       sh_c;
  logic [BCD_W-1:0]             s_fix_c;

  // One iteration: shift the working register right, then correct every BCD digit.
  assign sh_c = {s_q, b_q} >> 1;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    sub3 u_sub3 (
      .din    (sh_c[BIN_W + 4*g +: 4]),
      .dout_c (s_fix_c[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CONV;
      CONV:    if (count_q == CNT_W'(ITERS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BCD_CHECK_EN
  logic bad_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
`ifdef BCD_CHECK_EN
      bad_q   <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            s_q     <= bcd_in;
            b_q     <= '0;
            count_q <= '0;
`ifdef BCD_CHECK_EN
            bad_q   <= has_bad_digit(bcd_in);
`endif
          end
        end
        CONV: begin
          s_q     <= s_fix_c;
          b_q     <= sh_c[BIN_W-1:0];
          count_q <= count_q + CNT_W'(1);
        end
        DONE: begin
          done <= 1'b1;
`ifdef BCD_CHECK_EN
          result <= bad_q ? '0 : b_q;
          err    <= bad_q;
`else
          result <= b_q;
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef BCD_CHECK_EN
  assign err = 1'b0;
`endif

endmodule
